// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: frame/field widths, receiver FSM state type,
// response-frame layout and the CRC-8 (poly 0x07, init 0x00, MSB first)
// computed over a 16-bit header.
package spi_pkg;

    localparam int SPI_FRAME_W = 24;
    localparam int SPI_ADDR_W  = 7;
    localparam int SPI_DATA_W  = 8;
    localparam int SPI_CRC_W   = 8;
    localparam int SPI_CNT_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_EXEC,
        ST_CAPT
    } spi_slv_st_e;

    typedef struct packed {
        logic                  err;
        logic [SPI_ADDR_W-1:0] addr;
        logic [SPI_DATA_W-1:0] data;
        logic [SPI_CRC_W-1:0]  crc;
    } spi_resp_t;

    function automatic logic [SPI_CRC_W-1:0] crc8_of16(input logic [15:0] d);
        logic [SPI_CRC_W-1:0] c;
        logic                 fb;
        c = '0;
        for (int i = 15; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_slv_frame_rx_if.sv
// Register-file access bus between the SPI frame receiver and the register file.
// Signal names are from the receiver's point of view.
//   o_reg_wr_en  1-cycle write strobe
//   o_reg_rd_en  1-cycle read strobe
//   o_reg_addr   register address, valid with either strobe
//   o_reg_wdata  write data, valid with o_reg_wr_en
//   i_reg_rdata  read data, sampled 1 cycle after o_reg_rd_en
interface spi_slv_frame_rx_if;
    import spi_pkg::*;

    logic                  o_reg_wr_en;
    logic                  o_reg_rd_en;
    logic [SPI_ADDR_W-1:0] o_reg_addr;
    logic [SPI_DATA_W-1:0] o_reg_wdata;
    logic [SPI_DATA_W-1:0] i_reg_rdata;

    modport master (
        output o_reg_wr_en, o_reg_rd_en, o_reg_addr, o_reg_wdata,
        input  i_reg_rdata
    );

    modport slave (
        input  o_reg_wr_en, o_reg_rd_en, o_reg_addr, o_reg_wdata,
        output i_reg_rdata
    );
endinterface

// File: rtl/crc16to8_parallel.sv
// Single-cycle CRC-8 (poly 0x07, init 0x00) over a 16-bit word, MSB first.
//   i_data  16-bit message
//   o_crc   8-bit CRC
module crc16to8_parallel
    import spi_pkg::*;
(
    input  logic [15:0]          i_data,
    output logic [SPI_CRC_W-1:0] o_crc
);
    assign o_crc = crc8_of16(i_data);
endmodule

// File: rtl/gnrl_sync.sv
// Generic multi-flop synchronizer for a single asynchronous bit.
//   i_clk, i_rst_n  clock / async active-low reset
//   i_d             asynchronous input
//   o_q             synchronized output (STG flops deep, resets to RST_VAL)
module gnrl_sync #(
    parameter int   STG     = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [STG-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= {STG{RST_VAL}};
        else          sync_q <= {sync_q[STG-2:0], i_d};
    end

    assign o_q = sync_q[STG-1];
endmodule

// File: rtl/spi_slv_frame_rx.sv
// SPI mode-0 slave that receives 24-bit {wr, addr7, data8, crc8} command frames,
// checks length and CRC, issues one register write or read, and returns the
// response of the previous frame on MISO during the next frame.
//   i_clk, i_rst_n         system clock / async active-low reset
//   i_sclk, i_csb, i_mosi  asynchronous SPI pad inputs
//   o_miso, o_miso_oe      SPI data out and its output enable
//   reg_if                 register-file bus (strobes, address, data)
//   o_crc_err, o_len_err   1-cycle pulses for dropped frames
//   o_crc_err_cnt, o_len_err_cnt  saturating error counters
//
// state  | meaning
// IDLE   | no frame in progress
// SHIFT  | CSB low, collecting MOSI bits
// CHECK  | frame closed, length and CRC evaluated
// EXEC   | register write/read strobe issued
// CAPT   | response word built (read data sampled)
module spi_slv_frame_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STG  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sclk,
    input  logic                 i_csb,
    input  logic                 i_mosi,
    output logic                 o_miso,
    output logic                 o_miso_oe,
    spi_slv_frame_rx_if.master   reg_if,
    output logic                 o_crc_err,
    output logic                 o_len_err,
    output logic [ERR_CNT_W-1:0] o_crc_err_cnt,
    output logic [ERR_CNT_W-1:0] o_len_err_cnt
);
    logic sclk_s, csb_s, mosi_s;

    // CSB sync resets low together with its edge-detect flop, so a CSB that is
    // already low at reset release produces no fall; armed_q only opens the
    // frame logic once CSB has been seen high.
    gnrl_sync #(.STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sclk), .o_q(sclk_s));
    gnrl_sync #(.STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_csb (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_csb), .o_q(csb_s));
    gnrl_sync #(.STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_mosi), .o_q(mosi_s));

    spi_slv_st_e             state_q, state_d;
    logic [SPI_FRAME_W-1:0]  rx_sr_q, rx_sr_d;
    logic [SPI_FRAME_W-1:0]  tx_sr_q, tx_sr_d;
    logic [SPI_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    spi_resp_t               resp_q, resp_d;
    logic                    pend_q, pend_d;
    logic                    armed_q;
    logic                    sclk_s_q, csb_s_q;
    logic [ERR_CNT_W-1:0]    crc_cnt_q, crc_cnt_d;
    logic [ERR_CNT_W-1:0]    len_cnt_q, len_cnt_d;

    logic sclk_rise, sclk_fall, csb_fall, csb_rise, frame_on;
    logic wr_en, rd_en, crc_err, len_err;
    logic [SPI_CRC_W-1:0]  rx_crc, resp_crc;
    logic                  hdr_err;
    logic [SPI_DATA_W-1:0] hdr_data;

    assign sclk_rise = sclk_s & ~sclk_s_q;
    assign sclk_fall = ~sclk_s & sclk_s_q;
    assign csb_fall  = armed_q & csb_s_q & ~csb_s;
    assign csb_rise  = armed_q & ~csb_s_q & csb_s;
    assign frame_on  = armed_q & ~csb_s;

    crc16to8_parallel u_crc_rx (
        .i_data(rx_sr_q[23:8]),
        .o_crc (rx_crc)
    );

    // Response header: error frames are only built in CHECK, good ones in CAPT.
    assign hdr_err  = (state_q == ST_CHECK);
    assign hdr_data = hdr_err    ? '0 :
                      rx_sr_q[23] ? rx_sr_q[15:8] : reg_if.i_reg_rdata;

    crc16to8_parallel u_crc_resp (
        .i_data({hdr_err, rx_sr_q[22:16], hdr_data}),
        .o_crc (resp_crc)
    );

    always_comb begin
        state_d   = state_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        bit_cnt_d = bit_cnt_q;
        resp_d    = resp_q;
        pend_d    = pend_q;
        crc_cnt_d = crc_cnt_q;
        len_cnt_d = len_cnt_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        crc_err   = 1'b0;
        len_err   = 1'b0;

        if (csb_fall) begin
            tx_sr_d   = resp_q;
            bit_cnt_d = '0;
        end else begin
            if (sclk_rise && frame_on && bit_cnt_q != 5'd31)
                bit_cnt_d = bit_cnt_q + 5'd1;
            if (sclk_fall && frame_on)
                tx_sr_d = {tx_sr_q[22:0], 1'b0};
        end

        if (sclk_rise && state_q == ST_SHIFT)
            rx_sr_d = {rx_sr_q[22:0], mosi_s};

        // A new frame may start while the previous one is still being executed.
        if (csb_fall && (state_q == ST_CHECK || state_q == ST_EXEC || state_q == ST_CAPT))
            pend_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (csb_fall || pend_q) begin
                    state_d = ST_SHIFT;
                    pend_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (csb_rise) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (bit_cnt_q != 5'd24) begin
                    len_err = 1'b1;
                    resp_d  = {1'b1, rx_sr_q[22:16], 8'h00, resp_crc};
                    state_d = ST_IDLE;
                end else if (rx_crc != rx_sr_q[7:0]) begin
                    crc_err = 1'b1;
                    resp_d  = {1'b1, rx_sr_q[22:16], 8'h00, resp_crc};
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                wr_en   = rx_sr_q[23];
                rd_en   = ~rx_sr_q[23];
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                resp_d = {1'b0, rx_sr_q[22:16], hdr_data, resp_crc};
                if (pend_q || csb_fall) begin
                    state_d = ST_SHIFT;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (crc_err && crc_cnt_q != '1) crc_cnt_d = crc_cnt_q + 1'b1;
        if (len_err && len_cnt_q != '1) len_cnt_d = len_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            bit_cnt_q <= '0;
            resp_q    <= '0;
            pend_q    <= 1'b0;
            armed_q   <= 1'b0;
            sclk_s_q  <= 1'b0;
            csb_s_q   <= 1'b0;
            crc_cnt_q <= '0;
            len_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            bit_cnt_q <= bit_cnt_d;
            resp_q    <= resp_d;
            pend_q    <= pend_d;
            armed_q   <= armed_q | csb_s;
            sclk_s_q  <= sclk_s;
            csb_s_q   <= csb_s;
            crc_cnt_q <= crc_cnt_d;
            len_cnt_q <= len_cnt_d;
        end
    end

    assign o_miso             = tx_sr_q[23];
    assign o_miso_oe          = frame_on;
    assign reg_if.o_reg_wr_en = wr_en;
    assign reg_if.o_reg_rd_en = rd_en;
    assign reg_if.o_reg_addr  = (wr_en | rd_en) ? rx_sr_q[22:16] : '0;
    assign reg_if.o_reg_wdata = wr_en ? rx_sr_q[15:8] : '0;
    assign o_crc_err          = crc_err;
    assign o_len_err          = len_err;
    assign o_crc_err_cnt      = crc_cnt_q;
    assign o_len_err_cnt      = len_cnt_q;
endmodule

// File: tb/tb_spi_slv_frame_rx.sv
module tb_spi_slv_frame_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       csb = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, crc_err, len_err;
    logic [7:0] crc_cnt, len_cnt;

    int checks = 0;
    int errors = 0;
    int crc_pulses = 0;
    int len_pulses = 0;
    logic [15:0] ev_q[$];

    spi_slv_frame_rx_if rif();

    spi_slv_frame_rx #(.SYNC_STG(2), .ERR_CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sclk       (sclk),
        .i_csb        (csb),
        .i_mosi       (mosi),
        .o_miso       (miso),
        .o_miso_oe    (miso_oe),
        .reg_if       (rif),
        .o_crc_err    (crc_err),
        .o_len_err    (len_err),
        .o_crc_err_cnt(crc_cnt),
        .o_len_err_cnt(len_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rif.o_reg_wr_en) ev_q.push_back({1'b1, rif.o_reg_addr, rif.o_reg_wdata});
            if (rif.o_reg_rd_en) ev_q.push_back({1'b0, rif.o_reg_addr, rif.o_reg_wdata});
            if (crc_err) crc_pulses++;
            if (len_err) len_pulses++;
        end
    end

    // Reference CRC by polynomial long division of {d, 8'h00} by x^8+x^2+x+1.
    function automatic logic [7:0] crc_ref(input logic [15:0] d);
        logic [23:0] r;
        r = {d, 8'h00};
        for (int i = 23; i >= 8; i--)
            if (r[i]) r = r ^ (24'h107 << (i - 8));
        return r[7:0];
    endfunction

    function automatic logic [23:0] frm(input logic b, input logic [6:0] a, input logic [7:0] d);
        return {b, a, d, crc_ref({b, a, d})};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_outs"}, {3'b0, miso, miso_oe, rif.o_reg_wr_en, rif.o_reg_rd_en,
                             rif.o_reg_addr, rif.o_reg_wdata, crc_err, len_err}, 24'h0);
        chk({tag, "_cnts"}, {8'h00, crc_cnt, len_cnt}, 24'h0);
    endtask

    task automatic pop_ev(input string tag, input logic [15:0] exp);
        logic [15:0] e;
        e = 'x;
        if (ev_q.size() != 0) e = ev_q.pop_front();
        chk(tag, {8'h00, e}, {8'h00, exp});
    endtask

    // Mode-0 master at clk/8: MOSI changes with SCLK low, MISO sampled just before each rise.
    task automatic xfer(input logic [31:0] bits, input int n, input int gap, input int rst_at,
                        output logic [23:0] rx);
        rx  = '0;
        csb = 1'b0;
        for (int i = 0; i < n; i++) begin
            mosi = bits[n-1-i];
            if (i == rst_at) begin
                rst_n = 1'b0;
                tick(2);
                chk_idle("midrst");
                rst_n = 1'b1;
            end
            tick(4);
            rx   = {rx[22:0], miso};
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        tick(4);
        csb  = 1'b1;
        mosi = 1'b0;
        tick(gap);
    endtask

    logic [23:0] rx, f_w, tmp, prev, r23, r25;
    logic [6:0]  b_a[4];
    logic [7:0]  b_d[4];
    logic        b_w[4];

    initial begin
        rif.i_reg_rdata = 8'h00;
        tick(3);
        chk_idle("reset");
        rst_n = 1'b1;
        tick(10);

        // Write 0x40 <= 0x5B
        f_w = frm(1'b1, 7'h40, 8'h5B);
        xfer({8'h00, f_w}, 24, 10, -1, rx);
        chk("wr_miso", rx, 24'h0);
        chk("wr_nev", 24'(ev_q.size()), 24'd1);
        pop_ev("wr_ev", {1'b1, 7'h40, 8'h5B});

        // Read 0x6E, register returns 0xA6
        rif.i_reg_rdata = 8'hA6;
        xfer({8'h00, frm(1'b0, 7'h6E, 8'h00)}, 24, 10, -1, rx);
        chk("rd_miso", rx, frm(1'b0, 7'h40, 8'h5B));
        chk("rd_nev", 24'(ev_q.size()), 24'd1);
        pop_ev("rd_ev", {1'b0, 7'h6E, 8'h00});

        // Bad CRC
        xfer({8'h00, f_w ^ 24'h1}, 24, 10, -1, rx);
        chk("crc_miso", rx, frm(1'b0, 7'h6E, 8'hA6));
        chk("crc_nev", 24'(ev_q.size()), 24'd0);
        chk("crc_pulse", 24'(crc_pulses), 24'd1);
        chk("crc_cnt", {16'h0, crc_cnt}, 24'd1);

        // 23-bit frame: MISO carries 23 bits of the bad-CRC response
        xfer({9'h000, f_w[23:1]}, 23, 10, -1, rx);
        tmp = frm(1'b1, 7'h40, 8'h00);
        chk("len23_miso", rx, tmp >> 1);
        r23 = {1'b0, f_w[23:1]};

        // 25-bit frame: rx_sr keeps the last 24 bits
        xfer({7'h00, f_w, 1'b1}, 25, 10, -1, rx);
        tmp = frm(1'b1, r23[22:16], 8'h00);
        chk("len25_miso", rx, tmp << 1);
        r25 = {f_w[22:0], 1'b1};
        chk("len_nev", 24'(ev_q.size()), 24'd0);
        chk("len_pulse", 24'(len_pulses), 24'd2);
        chk("len_cnt", {16'h0, len_cnt}, 24'd2);

        // Back-to-back frames with minimum CSB high time
        b_w = '{1'b1, 1'b0, 1'b1, 1'b0};
        b_a = '{7'h11, 7'h33, 7'h55, 7'h7F};
        b_d = '{8'h22, 8'h00, 8'h66, 8'h00};
        rif.i_reg_rdata = 8'h3C;
        prev = frm(1'b1, r25[22:16], 8'h00);
        for (int k = 0; k < 4; k++) begin
            xfer({8'h00, frm(b_w[k], b_a[k], b_d[k])}, 24, (k == 3) ? 10 : 6, -1, rx);
            chk($sformatf("b2b_miso%0d", k), rx, prev);
            prev = frm(1'b0, b_a[k], b_w[k] ? b_d[k] : 8'h3C);
        end
        chk("b2b_nev", 24'(ev_q.size()), 24'd4);
        for (int k = 0; k < 4; k++)
            pop_ev($sformatf("b2b_ev%0d", k), {b_w[k], b_a[k], b_d[k]});
        xfer({8'h00, frm(1'b1, 7'h01, 8'h02)}, 24, 10, -1, rx);
        chk("b2b_last_miso", rx, prev);
        pop_ev("b2b_ev4", {1'b1, 7'h01, 8'h02});

        // Length-error counter saturation
        for (int k = 0; k < 256; k++) xfer(32'h0, 0, 6, -1, rx);
        tick(4);
        chk("len_sat", {16'h0, len_cnt}, 24'hFF);
        chk("len_pulse_all", 24'(len_pulses), 24'd258);
        chk("crc_cnt_hold", {16'h0, crc_cnt}, 24'd1);
        chk("sat_nev", 24'(ev_q.size()), 24'd0);

        // Reset in the middle of a write
        xfer({8'h00, frm(1'b1, 7'h12, 8'h34)}, 24, 10, 12, rx);
        chk("rst_nev", 24'(ev_q.size()), 24'd0);
        chk("rst_nolen", 24'(len_pulses), 24'd258);
        chk_idle("post_rst");
        xfer({8'h00, frm(1'b1, 7'h2A, 8'h7E)}, 24, 10, -1, rx);
        chk("rst_next_miso", rx, 24'h0);
        chk("rst_next_nev", 24'(ev_q.size()), 24'd1);
        pop_ev("rst_next_ev", {1'b1, 7'h2A, 8'h7E});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
